// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision divider.
package fp_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;
endpackage

// File: rtl/fp_div_if.sv
// Start/done operation bus shared by the FPU operation units.
interface fp_div_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        done;
    logic        busy;
    logic        div_zero;
    logic        ovf;
    logic        unf;

    modport master (output start, a, b, input r, done, busy, div_zero, ovf, unf);
    modport slave  (input start, a, b, output r, done, busy, div_zero, ovf, unf);
endinterface

// File: rtl/mant_divider.sv
// Restoring mantissa divider core: one quotient bit per step, remainder kept 25 bits wide.
module mant_divider
    import fp_pkg::*;
#(
    parameter int ITER = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MANT_W:0]   ma_i,
    input  logic [MANT_W:0]   mb_i,
    output logic [ITER-1:0]   q_o,
    output logic [MANT_W+1:0] rem_o,
    output logic              rem_zero_o
);
    logic [MANT_W+1:0] rem_q, rem_d, diff;
    logic [MANT_W:0]   mb_q;
    logic [ITER-1:0]   q_q, q_d;
    logic              ge;

    always_comb begin
        ge    = (rem_q >= {1'b0, mb_q});
        diff  = ge ? rem_q - {1'b0, mb_q} : rem_q;
        rem_d = diff << 1;
        q_d   = {q_q[ITER-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            mb_q  <= '0;
            q_q   <= '0;
        end else if (load_i) begin
            rem_q <= {1'b0, ma_i};
            mb_q  <= mb_i;
            q_q   <= '0;
        end else if (step_i) begin
            rem_q <= rem_d;
            q_q   <= q_d;
        end
    end

    assign q_o        = q_q;
    assign rem_o      = rem_q;
    assign rem_zero_o = (rem_q == '0);
endmodule

// File: rtl/fp_div.sv
// Sequential IEEE-754 single divider, RNE rounding, denormals flushed to zero.
// Define FP_DIV_SPECIALS_EN to decode exponent-255 operands as infinities/NaNs.
//   state  | meaning
//   IDLE   | wait for start, latch operands
//   UNPACK | decode operands, early exit on zero/special operands
//   DIVIDE | one quotient bit per cycle for ITER cycles
//   NORM   | align quotient, extract guard and sticky
//   ROUND  | round to nearest even, range check, write R and flags
//   DONE   | one-cycle done pulse
module fp_div
    import fp_pkg::*;
#(
    parameter int ITER = 27
) (
    input  logic    clk,
    input  logic    rst_n,
    fp_div_if.slave bus
);
    state_e             state_q;
    logic [31:0]        a_q, b_q, r_q;
    logic               sign_q, done_q, busy_q, div_zero_q, ovf_q, unf_q;
    logic               guard_q, sticky_q;
    logic signed [9:0]  exp_q;
    logic [4:0]         cnt_q;
    logic [MANT_W-1:0]  frac_q;

    logic [EXP_W-1:0]   ea, eb;
    logic               a_zero, b_zero, sign_d, early_d, div_zero_d;
    logic signed [9:0]  exp_d;
    logic [31:0]        early_r_d;
`ifdef FP_DIV_SPECIALS_EN
    logic               a_inf, b_inf, a_nan, b_nan;
`endif

    always_comb begin
        ea         = a_q[MANT_W +: EXP_W];
        eb         = b_q[MANT_W +: EXP_W];
        a_zero     = (ea == '0);
        b_zero     = (eb == '0);
        sign_d     = a_q[31] ^ b_q[31];
        exp_d      = {2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS);
`ifdef FP_DIV_SPECIALS_EN
        a_inf      = (ea == '1) && (a_q[MANT_W-1:0] == '0);
        b_inf      = (eb == '1) && (b_q[MANT_W-1:0] == '0);
        a_nan      = (ea == '1) && (a_q[MANT_W-1:0] != '0);
        b_nan      = (eb == '1) && (b_q[MANT_W-1:0] != '0);
`endif
        early_d    = 1'b1;
        div_zero_d = 1'b0;
        early_r_d  = {sign_d, 31'd0};
        if (a_zero && b_zero) early_r_d = QNAN;
`ifdef FP_DIV_SPECIALS_EN
        else if (a_nan || b_nan || (a_inf && b_inf)) early_r_d = QNAN;
        else if (a_inf) early_r_d = POS_INF | {sign_d, 31'd0};
        else if (b_inf) early_r_d = {sign_d, 31'd0};
`endif
        else if (b_zero) begin
            early_r_d  = POS_INF | {sign_d, 31'd0};
            div_zero_d = 1'b1;
        end
        else if (a_zero) early_r_d = {sign_d, 31'd0};
        else early_d = 1'b0;
    end

    logic [ITER-1:0]   quo;
    logic [MANT_W+1:0] rem_unused;
    logic              rem_zero;

    mant_divider #(.ITER(ITER)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == S_UNPACK),
        .step_i     (state_q == S_DIVIDE),
        .ma_i       ({1'b1, a_q[MANT_W-1:0]}),
        .mb_i       ({1'b1, b_q[MANT_W-1:0]}),
        .q_o        (quo),
        .rem_o      (rem_unused),
        .rem_zero_o (rem_zero)
    );

    // qn drops the leading one; it holds fraction, guard and sticky bits.
    logic [ITER-2:0]   qn;
    logic signed [9:0] exp_n;
    logic              inc, carry;
    logic [MANT_W-1:0] frac_rnd;
    logic signed [9:0] exp_rnd;

    always_comb begin
        qn      = quo[ITER-1] ? quo[ITER-2:0] : {quo[ITER-3:0], 1'b0};
        exp_n   = quo[ITER-1] ? exp_q : exp_q - 10'sd1;
        inc     = guard_q & (sticky_q | frac_q[0]);
        {carry, frac_rnd} = {1'b0, frac_q} + {{MANT_W{1'b0}}, inc};
        exp_rnd = carry ? exp_q + 10'sd1 : exp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            cnt_q      <= '0;
            frac_q     <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    div_zero_q <= 1'b0;
                    ovf_q      <= 1'b0;
                    unf_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_UNPACK;
                end
                S_UNPACK: begin
                    sign_q <= sign_d;
                    exp_q  <= exp_d;
                    if (early_d) begin
                        r_q        <= early_r_d;
                        div_zero_q <= div_zero_d;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q   <= 5'(ITER - 1);
                        state_q <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (cnt_q == '0) state_q <= S_NORM;
                    else             cnt_q   <= cnt_q - 5'd1;
                end
                S_NORM: begin
                    frac_q   <= qn[ITER-2 -: MANT_W];
                    guard_q  <= qn[ITER-2-MANT_W];
                    sticky_q <= (|qn[ITER-3-MANT_W:0]) | ~rem_zero;
                    exp_q    <= exp_n;
                    state_q  <= S_ROUND;
                end
                S_ROUND: begin
                    if (exp_rnd >= 10'sd255) begin
                        r_q   <= POS_INF | {sign_q, 31'd0};
                        ovf_q <= 1'b1;
                    end else if (exp_rnd <= 10'sd0) begin
                        r_q   <= {sign_q, 31'd0};
                        unf_q <= 1'b1;
                    end else begin
                        r_q <= {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.r        = r_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.div_zero = div_zero_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule
